// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp behind a 32-bit register port,
// with a tick prescaler and a level timer interrupt.
module mtimer #(
  parameter int unsigned DIV = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        timer_intr
);

  localparam logic [15:0] PRESC_MAX = 16'(DIV - 1);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        intr_q, intr_d;
  logic        tick;

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    presc_d    = presc_q;
    snap_d     = snap_q;
    rdata_d    = rdata_q;
    rvalid_d   = re;
    tick       = ctrl_q[0] && (presc_q == PRESC_MAX);

    if (ctrl_q[0]) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    // A write to either mtime half swallows a coincident tick.
    if (we && addr == A_MTIME_LO) begin
      mtime_d = {mtime_q[63:32], wdata};
    end else if (we && addr == A_MTIME_HI) begin
      mtime_d = {wdata, mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (we) begin
      case (addr)
        A_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wdata};
        A_CMP_HI: mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        A_CTRL: begin
          ctrl_d = wdata[1:0];
          if (!wdata[0]) presc_d = 16'd0;
        end
        default: ;
      endcase
    end

    // Reads see pre-write state; the lo read freezes hi for a coherent pair.
    if (re) begin
      case (addr)
        A_MTIME_LO: begin
          rdata_d = mtime_q[31:0];
          snap_d  = mtime_q[63:32];
        end
        A_MTIME_HI: rdata_d = snap_q;
        A_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        A_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        A_CTRL:     rdata_d = {30'd0, ctrl_q};
        default:    rdata_d = 32'd0;
      endcase
    end

    intr_d = ctrl_d[1] && (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      ctrl_q     <= '0;
      presc_q    <= '0;
      snap_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      snap_q     <= snap_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      intr_q     <= intr_d;
    end
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign timer_intr = intr_q;

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: two instances (DIV=4 and DIV=1) share one stimulus stream
// and are checked every cycle against a behavioural model plus literal vectors.
module tb_mtimer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;

  logic [31:0] rdata_a [2];
  logic        rvalid_a [2];
  logic        intr_a [2];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mtimer #(.DIV(4)) u_div4 (
    .clk(clk), .rstn(rstn), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata_a[0]), .rvalid(rvalid_a[0]), .timer_intr(intr_a[0])
  );

  mtimer #(.DIV(1)) u_div1 (
    .clk(clk), .rstn(rstn), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata_a[1]), .rvalid(rvalid_a[1]), .timer_intr(intr_a[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int unsigned divs [2] = '{4, 1};
  logic [63:0] m_time [2];
  logic [63:0] m_cmp [2];
  logic        m_en [2];
  logic        m_ie [2];
  int unsigned m_pre [2];
  logic [31:0] m_snap [2];
  logic [31:0] m_rd [2];
  logic        m_rv [2];
  logic        m_intr [2];

  logic [63:0] t_n, c_n;
  logic        en_n, ie_n, fire, mwrite;
  int unsigned pre_n;
  logic [31:0] rd_n, snap_n;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        m_time[i] <= 64'd0;  m_cmp[i] <= {64{1'b1}};
        m_en[i] <= 1'b0;     m_ie[i] <= 1'b0;  m_pre[i] <= 0;
        m_snap[i] <= 32'd0;  m_rd[i] <= 32'd0;
        m_rv[i] <= 1'b0;     m_intr[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        t_n = m_time[i]; c_n = m_cmp[i]; en_n = m_en[i]; ie_n = m_ie[i];
        snap_n = m_snap[i]; rd_n = m_rd[i];
        fire = m_en[i] && (m_pre[i] == divs[i] - 1);
        pre_n = m_en[i] ? (fire ? 0 : m_pre[i] + 1) : m_pre[i];
        if (re) begin
          case (addr)
            3'd0: begin rd_n = m_time[i][31:0]; snap_n = m_time[i][63:32]; end
            3'd1: rd_n = m_snap[i];
            3'd2: rd_n = m_cmp[i][31:0];
            3'd3: rd_n = m_cmp[i][63:32];
            3'd4: rd_n = {30'd0, m_ie[i], m_en[i]};
            default: rd_n = 32'd0;
          endcase
        end
        mwrite = we && (addr == 3'd0 || addr == 3'd1);
        if (we) begin
          case (addr)
            3'd0: t_n[31:0]  = wdata;
            3'd1: t_n[63:32] = wdata;
            3'd2: c_n[31:0]  = wdata;
            3'd3: c_n[63:32] = wdata;
            3'd4: begin en_n = wdata[0]; ie_n = wdata[1]; if (!wdata[0]) pre_n = 0; end
            default: ;
          endcase
        end
        if (fire && !mwrite) t_n = m_time[i] + 64'd1;
        m_time[i] <= t_n;  m_cmp[i] <= c_n;
        m_en[i] <= en_n;   m_ie[i] <= ie_n;  m_pre[i] <= pre_n;
        m_snap[i] <= snap_n;  m_rd[i] <= rd_n;  m_rv[i] <= re;
        m_intr[i] <= ie_n && (t_n >= c_n);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_rvalid[%0d]", i), 64'(rvalid_a[i]), 64'(m_rv[i]));
      chk($sformatf("model_intr[%0d]", i), 64'(intr_a[i]), 64'(m_intr[i]));
      if (m_rv[i]) chk($sformatf("model_rdata[%0d]", i), 64'(rdata_a[i]), 64'(m_rd[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] r0, output logic [31:0] r1);
    re = 1'b1; addr = a;
    @(negedge clk);
    re = 1'b0; r0 = rdata_a[0]; r1 = rdata_a[1];
  endtask

  task automatic rw(input logic [2:0] a, input logic [31:0] d,
                    output logic [31:0] r0, output logic [31:0] r1);
    we = 1'b1; re = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; re = 1'b0; r0 = rdata_a[0]; r1 = rdata_a[1];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [31:0] rst_exp [8] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd0, 32'd0, 32'd0, 32'd0};

  initial begin
    logic [31:0] r0, r1, lo0, lo1, hi0, hi1;
    int cnt, first1;

    #23 rstn = 1'b1;
    @(negedge clk);

    chk("reset_intr4", 64'(intr_a[0]), 64'd0);
    chk("reset_intr1", 64'(intr_a[1]), 64'd0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), r0, r1);
      chk($sformatf("reset_rd4_a%0d", a), 64'(r0), 64'(rst_exp[a]));
      chk($sformatf("reset_rd1_a%0d", a), 64'(r1), 64'(rst_exp[a]));
      chk($sformatf("reset_rvalid_a%0d", a), 64'(rvalid_a[0]), 64'd1);
    end

    // Count and interrupt: DIV=4 fires after 40 cycles, DIV=1 after 10.
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd10);
    wr(3'd4, 32'd3);
    first1 = -1;
    cnt = 0;
    while (!intr_a[0] && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (intr_a[1] && first1 < 0) first1 = cnt;
    end
    chk("intr_rise_div4", 64'(cnt), 64'd40);
    chk("intr_rise_div1", 64'(first1), 64'd10);
    wr(3'd2, 32'd100);
    chk("intr_clear_div4", 64'(intr_a[0]), 64'd0);
    chk("intr_clear_div1", 64'(intr_a[1]), 64'd0);

    // Lo/hi snapshot across a carry.
    for (int k = 0; k < 3; k++) begin
      wr(3'd4, 32'd0);
      wr(3'd0, 32'hFFFF_FFFE);
      wr(3'd1, 32'd5);
      wr(3'd4, 32'd1);
      idle(k);
      rd(3'd0, lo0, lo1);
      rd(3'd1, hi0, hi1);
      chk($sformatf("carry_pair_k%0d", k), {hi1, lo1}, 64'h5_FFFF_FFFE + 64'(k));
    end

    // Write colliding with a tick.
    wr(3'd4, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);
    idle(2);
    wr(3'd0, 32'd7);
    rd(3'd0, r0, r1);
    chk("collide_first", 64'(r1), 64'd7);
    rd(3'd0, r0, r1);
    chk("collide_second", 64'(r1), 64'd8);

    // Wrap through zero with mtimecmp=2.
    wr(3'd4, 32'd0);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd2);
    wr(3'd4, 32'd3);
    chk("wrap_at_max", 64'(intr_a[1]), 64'd1);
    idle(1);
    chk("wrap_at_0", 64'(intr_a[1]), 64'd0);
    idle(1);
    chk("wrap_at_1", 64'(intr_a[1]), 64'd0);
    idle(1);
    chk("wrap_at_2", 64'(intr_a[1]), 64'd1);
    rd(3'd4, r0, r1);
    chk("ctrl_read", 64'(r1), 64'd3);

    // Asynchronous reset between edges.
    #2 rstn = 1'b0;
    #1;
    chk("async_intr4", 64'(intr_a[0]), 64'd0);
    chk("async_intr1", 64'(intr_a[1]), 64'd0);
    chk("async_rdata4", 64'(rdata_a[0]), 64'd0);
    chk("async_rdata1", 64'(rdata_a[1]), 64'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    rd(3'd0, r0, r1);
    chk("post_rst_lo4", 64'(r0), 64'd0);
    chk("post_rst_lo1", 64'(r1), 64'd0);
    rd(3'd1, r0, r1);
    chk("post_rst_hi1", 64'(r1), 64'd0);

    // Same-cycle write and read returns the old value; reserved reads as 0.
    rw(3'd2, 32'd5, r0, r1);
    chk("rw_old_value", 64'(r1), 64'hFFFF_FFFF);
    rd(3'd2, r0, r1);
    chk("rw_new_value", 64'(r0), 64'd5);
    wr(3'd5, 32'h1234_5678);
    rd(3'd5, r0, r1);
    chk("reserved_read", 64'(r0), 64'd0);

    // First tick DIV cycles after EN is written.
    wr(3'd4, 32'd1);
    idle(3);
    rd(3'd0, r0, r1);
    chk("first_tick_div4_before", 64'(r0), 64'd0);
    chk("first_tick_div1", 64'(r1), 64'd3);
    rd(3'd0, r0, r1);
    chk("first_tick_div4_after", 64'(r0), 64'd1);
    chk("first_tick_div1_next", 64'(r1), 64'd4);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
